// File: rtl/reg_file_pkg.sv
// Shared constants for the accumulator datapath register file: default geometry,
// architectural register indices and stack bounds.
package reg_file_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 8;

   localparam int IDX_WR = 0;
   localparam int IDX_MA = 1;
   localparam int IDX_AR = 2;
   localparam int IDX_NA = 3;
   localparam int IDX_RV = 4;
   localparam int IDX_SP = 5;
   localparam int IDX_RA = 6;
   localparam int IDX_TP = 7;

   localparam logic [15:0] SP_RESET_C = 16'h7FFE;
   localparam logic [15:0] SP_LIMIT_C = 16'h4000;

endpackage

// File: rtl/reg_file_param_sp_engine.sv
// Stack-pointer engine: computes the next SP for push/pop and keeps the sticky
// overflow/underflow flags.
module sp_engine #(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] SP_RESET = 16'h7FFE,
   parameter logic [DATA_W-1:0] SP_LIMIT = 16'h4000,
   parameter int                SP_STEP  = 2
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_sp,
   input  logic [DATA_W-1:0] i_sp,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_flag_clr,
   output logic [DATA_W-1:0] o_sp_next,
   output logic              o_sp_we,
   output logic              o_overflow,
   output logic              o_underflow
);

   // Bounds are checked one bit wider so neither SP - step nor SP + step can wrap.
   localparam logic [DATA_W:0] STEP_X  = (DATA_W+1)'(SP_STEP);
   localparam logic [DATA_W:0] LOW_X   = {1'b0, SP_LIMIT} + STEP_X;
   localparam logic [DATA_W:0] RESET_X = {1'b0, SP_RESET};

   logic [DATA_W:0] w_sp_x;
   logic            w_do_push;
   logic            w_do_pop;
   logic            w_push_fault;
   logic            w_pop_fault;
   logic            r_overflow;
   logic            r_underflow;

   assign w_sp_x       = {1'b0, i_sp};
   assign w_do_push    = !i_wr_sp && i_push && !i_pop;
   assign w_do_pop     = !i_wr_sp && i_pop && !i_push;
   assign w_push_fault = w_do_push && (w_sp_x < LOW_X);
   assign w_pop_fault  = w_do_pop && ((w_sp_x + STEP_X) > RESET_X);

   assign o_sp_we   = (w_do_push && !w_push_fault) || (w_do_pop && !w_pop_fault);
   assign o_sp_next = w_do_push ? (i_sp - STEP_X[DATA_W-1:0]) : (i_sp + STEP_X[DATA_W-1:0]);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push_fault)    r_overflow <= 1'b1;
         else if (i_flag_clr) r_overflow <= 1'b0;
         if (w_pop_fault)     r_underflow <= 1'b1;
         else if (i_flag_clr) r_underflow <= 1'b0;
      end
   end

   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule

// File: rtl/reg_file_param.sv
// General register file: NUM_REGS x DATA_W storage, two combinational read ports
// with write-first bypass, one write port and a built-in stack-pointer engine.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                NUM_REGS  = DEF_NUM_REGS,
   parameter int                SP_IDX    = IDX_SP,
   parameter logic [DATA_W-1:0] SP_RESET  = DATA_W'(SP_RESET_C),
   parameter logic [DATA_W-1:0] SP_LIMIT  = DATA_W'(SP_LIMIT_C),
   parameter int                SP_STEP   = 2,
   parameter bit                HARD_ZERO = 1'b0,
   localparam int               ADDR_W    = $clog2(NUM_REGS)
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              sp_push,
   input  logic              sp_pop,
   input  logic              flag_clr,
   output logic [DATA_W-1:0] sp,
   output logic              sp_overflow,
   output logic              sp_underflow
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              w_wr_ok;
   logic              w_wr_sp;
   logic              w_rd_a_ok;
   logic              w_rd_b_ok;
   logic [DATA_W-1:0] w_sp_next;
   logic              w_sp_we;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;

   // A write is legal only for an in-range index that is not the hardwired zero.
   assign w_wr_ok   = wr_en && (int'(wr_addr) < NUM_REGS) && !(HARD_ZERO && wr_addr == '0);
   assign w_wr_sp   = w_wr_ok && (int'(wr_addr) == SP_IDX);
   assign w_rd_a_ok = (int'(rd_addr_a) < NUM_REGS) && !(HARD_ZERO && rd_addr_a == '0);
   assign w_rd_b_ok = (int'(rd_addr_b) < NUM_REGS) && !(HARD_ZERO && rd_addr_b == '0);

   sp_engine #(
      .DATA_W   (DATA_W),
      .SP_RESET (SP_RESET),
      .SP_LIMIT (SP_LIMIT),
      .SP_STEP  (SP_STEP)
   ) u_sp_engine (
      .i_clk       (CLK),
      .i_rst       (RST),
      .i_wr_sp     (w_wr_sp),
      .i_sp        (r_regs[SP_IDX]),
      .i_push      (sp_push),
      .i_pop       (sp_pop),
      .i_flag_clr  (flag_clr),
      .o_sp_next   (w_sp_next),
      .o_sp_we     (w_sp_we),
      .o_overflow  (sp_overflow),
      .o_underflow (sp_underflow)
   );

   // sp_engine never asserts sp_we on a cycle with an explicit SP write.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end else begin
         if (w_wr_ok) r_regs[wr_addr] <= wr_data;
         if (w_sp_we) r_regs[SP_IDX]  <= w_sp_next;
      end
   end

   always_comb begin
      w_rd_a = '0;
      w_rd_b = '0;
      if (w_rd_a_ok) w_rd_a = r_regs[rd_addr_a];
      if (w_rd_b_ok) w_rd_b = r_regs[rd_addr_b];
      if (w_wr_ok && wr_addr == rd_addr_a) w_rd_a = wr_data;
      if (w_wr_ok && wr_addr == rd_addr_b) w_rd_b = wr_data;
   end

   assign rd_data_a = w_rd_a;
   assign rd_data_b = w_rd_b;
   assign sp        = r_regs[SP_IDX];

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default instance driven from a vector table,
// plus a HARD_ZERO / NUM_REGS=6 instance exercised by hand sequences.
module tb_reg_file_param;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;

   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic [2:0]  rd_addr_a = '0;
   logic [2:0]  rd_addr_b = '0;
   logic        sp_push = 1'b0;
   logic        sp_pop = 1'b0;
   logic        flag_clr = 1'b0;
   logic [15:0] rd_data_a, rd_data_b, sp;
   logic        sp_overflow, sp_underflow;

   logic        hz_wr_en = 1'b0;
   logic [2:0]  hz_wr_addr = '0;
   logic [15:0] hz_wr_data = '0;
   logic [2:0]  hz_rd_addr_a = '0;
   logic [2:0]  hz_rd_addr_b = '0;
   logic        hz_push = 1'b0;
   logic        hz_pop = 1'b0;
   logic        hz_clr = 1'b0;
   logic [15:0] hz_rd_data_a, hz_rd_data_b, hz_sp;
   logic        hz_ov, hz_ud;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   reg_file_param dut (
      .CLK(CLK), .RST(RST),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
      .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .sp_push(sp_push), .sp_pop(sp_pop), .flag_clr(flag_clr),
      .sp(sp), .sp_overflow(sp_overflow), .sp_underflow(sp_underflow)
   );

   reg_file_param #(.NUM_REGS(6), .HARD_ZERO(1'b1)) dut_hz (
      .CLK(CLK), .RST(RST),
      .wr_en(hz_wr_en), .wr_addr(hz_wr_addr), .wr_data(hz_wr_data),
      .rd_addr_a(hz_rd_addr_a), .rd_data_a(hz_rd_data_a),
      .rd_addr_b(hz_rd_addr_b), .rd_data_b(hz_rd_data_b),
      .sp_push(hz_push), .sp_pop(hz_pop), .flag_clr(hz_clr),
      .sp(hz_sp), .sp_overflow(hz_ov), .sp_underflow(hz_ud)
   );

   typedef struct {
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic        pu;
      logic        po;
      logic        cl;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [15:0] esp;
      logic        eov;
      logic        eud;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic we, logic [2:0] wa, logic [15:0] wd,
                               logic [2:0] ra, logic [2:0] rb,
                               logic pu, logic po, logic cl,
                               logic [15:0] ea, logic [15:0] eb, logic [15:0] esp,
                               logic eov, logic eud);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
      v.pu = pu; v.po = po; v.cl = cl;
      v.ea = ea; v.eb = eb; v.esp = esp; v.eov = eov; v.eud = eud;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; sp_push = 1'b0; sp_pop = 1'b0; flag_clr = 1'b0;
   endtask

   initial begin
      // Vectors: inputs applied, outputs checked before the edge, then clocked.
      // Expected sp/flags are the state left by the previous vectors.
      tbl.push_back(mk(1,2,16'hBEEF, 2,3, 0,0,0, 16'hBEEF,16'h0000,16'h7FFE, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 2,2, 0,0,0, 16'hBEEF,16'hBEEF,16'h7FFE, 0,0));
      tbl.push_back(mk(1,3,16'h1111, 3,2, 0,0,0, 16'h1111,16'hBEEF,16'h7FFE, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,3, 1,0,0, 16'h7FFE,16'h1111,16'h7FFE, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,2, 1,0,0, 16'h7FFC,16'hBEEF,16'h7FFC, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,5, 1,0,0, 16'h7FFA,16'h7FFA,16'h7FFA, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,3, 0,1,0, 16'h7FF8,16'h1111,16'h7FF8, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,5, 1,1,0, 16'h7FFA,16'h7FFA,16'h7FFA, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,0, 0,0,0, 16'h7FFA,16'h0000,16'h7FFA, 0,0));
      tbl.push_back(mk(1,5,16'h4002, 5,2, 0,0,0, 16'h4002,16'hBEEF,16'h7FFA, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,5, 1,0,0, 16'h4002,16'h4002,16'h4002, 0,0));
      tbl.push_back(mk(1,5,16'h4000, 5,5, 1,0,0, 16'h4000,16'h4000,16'h4000, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,1, 1,0,0, 16'h4000,16'h0000,16'h4000, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,1, 0,0,0, 16'h4000,16'h0000,16'h4000, 1,0));
      tbl.push_back(mk(0,0,16'h0000, 5,1, 0,0,1, 16'h4000,16'h0000,16'h4000, 1,0));
      tbl.push_back(mk(1,5,16'h7FFE, 5,4, 0,0,0, 16'h7FFE,16'h0000,16'h4000, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,4, 0,1,0, 16'h7FFE,16'h0000,16'h7FFE, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,4, 0,1,1, 16'h7FFE,16'h0000,16'h7FFE, 0,1));
      tbl.push_back(mk(0,0,16'h0000, 5,4, 0,0,1, 16'h7FFE,16'h0000,16'h7FFE, 0,1));
      tbl.push_back(mk(0,0,16'h0000, 5,4, 1,0,0, 16'h7FFE,16'h0000,16'h7FFE, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 5,4, 0,1,0, 16'h7FFC,16'h0000,16'h7FFC, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 2,3, 0,0,0, 16'hBEEF,16'h1111,16'h7FFE, 0,0));
      tbl.push_back(mk(1,0,16'hAAAA, 0,0, 0,0,0, 16'hAAAA,16'hAAAA,16'h7FFE, 0,0));
      tbl.push_back(mk(0,0,16'h0000, 0,7, 0,0,0, 16'hAAAA,16'h0000,16'h7FFE, 0,0));

      // Reset state
      RST = 1'b1;
      step();
      RST = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_addr_a = 3'(i);
         rd_addr_b = 3'(7 - i);
         #1;
         chk($sformatf("rst_a%0d", i), rd_data_a, (i == 5) ? 16'h7FFE : 16'h0000);
         chk($sformatf("rst_b%0d", 7 - i), rd_data_b, ((7 - i) == 5) ? 16'h7FFE : 16'h0000);
      end
      chk("rst_sp", sp, 16'h7FFE);
      chk("rst_ov", {15'b0, sp_overflow}, 16'h0);
      chk("rst_ud", {15'b0, sp_underflow}, 16'h0);

      // Table-driven main sequence
      for (int k = 0; k < tbl.size(); k++) begin
         wr_en = tbl[k].we; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
         rd_addr_a = tbl[k].ra; rd_addr_b = tbl[k].rb;
         sp_push = tbl[k].pu; sp_pop = tbl[k].po; flag_clr = tbl[k].cl;
         #1;
         chk($sformatf("v%0d_rda", k), rd_data_a, tbl[k].ea);
         chk($sformatf("v%0d_rdb", k), rd_data_b, tbl[k].eb);
         chk($sformatf("v%0d_sp", k), sp, tbl[k].esp);
         chk($sformatf("v%0d_ov", k), {15'b0, sp_overflow}, {15'b0, tbl[k].eov});
         chk($sformatf("v%0d_ud", k), {15'b0, sp_underflow}, {15'b0, tbl[k].eud});
         step();
      end
      idle();

      // Reset beats a simultaneous write, push and a set overflow flag
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h4000;
      step();
      idle();
      sp_push = 1'b1;
      step();
      idle();
      #1;
      chk("pre_rst_ov", {15'b0, sp_overflow}, 16'h1);
      RST = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5555; sp_push = 1'b1;
      step();
      RST = 1'b0;
      idle();
      rd_addr_a = 3'd2; rd_addr_b = 3'd0;
      #1;
      chk("rstwin_r2", rd_data_a, 16'h0000);
      chk("rstwin_r0", rd_data_b, 16'h0000);
      chk("rstwin_sp", sp, 16'h7FFE);
      chk("rstwin_ov", {15'b0, sp_overflow}, 16'h0);

      // HARD_ZERO instance: reg0 and index 7 ignore writes and read 0
      hz_wr_en = 1'b1; hz_wr_addr = 3'd1; hz_wr_data = 16'hABCD;
      step();
      hz_wr_addr = 3'd0; hz_wr_data = 16'h1234; hz_rd_addr_a = 3'd0;
      #1;
      chk("hz_bypass0", hz_rd_data_a, 16'h0000);
      step();
      hz_wr_addr = 3'd7; hz_rd_addr_a = 3'd7;
      #1;
      chk("hz_bypass7", hz_rd_data_a, 16'h0000);
      step();
      hz_wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         hz_rd_addr_a = 3'(i);
         #1;
         chk($sformatf("hz_r%0d", i), hz_rd_data_a,
             (i == 1) ? 16'hABCD : (i == 5) ? 16'h7FFE : 16'h0000);
      end
      hz_rd_addr_b = 3'd6;
      #1;
      chk("hz_rb6", hz_rd_data_b, 16'h0000);
      chk("hz_sp", hz_sp, 16'h7FFE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
